// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI responder streaming a test-pattern ADC sample and capturing mosi words.
module adc_spi_responder #(
  parameter int DATA_W = 12,
  parameter int LEAD_Z = 4,
  localparam int FRAME_LEN = LEAD_Z + DATA_W,
  localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 direction,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [DATA_W-1:0]    sample,
  output logic [FRAME_LEN-1:0] rx_word,
  output logic                 frame_done,
  output logic                 frame_abort
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  localparam logic [DATA_W-1:0] SAMPLE_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_LEN);

  logic [2:0] cs_s, sclk_s;
  logic [1:0] mosi_s;
  logic [1:0] fill_q;
  logic       armed_q;

  state_t                state_q, state_n;
  logic [FRAME_LEN-1:0]  tx_sr_q, tx_sr_n;
  logic [FRAME_LEN-1:0]  rx_sr_q, rx_sr_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [DATA_W-1:0]     sample_q, sample_n;
  logic [FRAME_LEN-1:0]  rx_word_q, rx_word_n;
  logic                  done_q, done_n;
  logic                  abort_q, abort_n;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  // A cs_n low that was already present at reset release must not look like a
  // fresh falling edge, so frames are only armed once a real high level is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s    <= 3'b111;
      sclk_s  <= 3'b111;
      mosi_s  <= 2'b00;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      cs_s   <= {cs_s[1:0], cs_n};
      sclk_s <= {sclk_s[1:0], sclk};
      mosi_s <= {mosi_s[0], mosi};
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && cs_s[1]) armed_q <= 1'b1;
    end
  end

  assign cs_fall   =  cs_s[2]   & ~cs_s[1];
  assign cs_rise   = ~cs_s[2]   &  cs_s[1];
  assign sclk_rise = ~sclk_s[2] &  sclk_s[1];
  assign sclk_fall =  sclk_s[2] & ~sclk_s[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      cnt_q     <= '0;
      sample_q  <= '0;
      rx_word_q <= '0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      tx_sr_q   <= tx_sr_n;
      rx_sr_q   <= rx_sr_n;
      cnt_q     <= cnt_n;
      sample_q  <= sample_n;
      rx_word_q <= rx_word_n;
      done_q    <= done_n;
      abort_q   <= abort_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    tx_sr_n   = tx_sr_q;
    rx_sr_n   = rx_sr_q;
    cnt_n     = cnt_q;
    sample_n  = sample_q;
    rx_word_n = rx_word_q;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          tx_sr_n = FRAME_LEN'(sample_q);
          rx_sr_n = '0;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // cs_n edges win over any sclk edge seen in the same clk
        if (cs_rise) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (sclk_rise) begin
          rx_sr_n = {rx_sr_q[FRAME_LEN-2:0], mosi_s[1]};
        end else if (sclk_fall) begin
          tx_sr_n = {tx_sr_q[FRAME_LEN-2:0], 1'b0};
          cnt_n   = cnt_q + CNT_ONE;
          if (cnt_n == CNT_LAST) state_n = WAIT_CS;
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          done_n    = 1'b1;
          rx_word_n = rx_sr_q;
          sample_n  = direction ? sample_q + SAMPLE_ONE : sample_q - SAMPLE_ONE;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign miso        = (state_q == SHIFT) ? tx_sr_q[FRAME_LEN-1] : 1'b0;
  assign miso_oe     = (state_q == SHIFT);
  assign sample      = sample_q;
  assign rx_word     = rx_word_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter DATA_W, default 12, sample width in bits.
REQ-002 Parameter LEAD_Z, default 4, leading zero bits sent before the sample; frame length FRAME_LEN = LEAD_Z + DATA_W, which is 16 by default.
REQ-003 Port clk, input, 1 bit: the single system clock; every register in the block SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port cs_n, input, 1 bit: serial chip select from the initiator, active low, asynchronous to clk.
REQ-006 Port sclk, input, 1 bit: serial clock from the initiator, asynchronous to clk, at most clk/8.
REQ-007 Port mosi, input, 1 bit: serial data from the initiator, asynchronous to clk.
REQ-008 Port direction, input, 1 bit: sample pattern direction; 1 = count up, 0 = count down.
REQ-009 Port miso, output, 1 bit: serial sample data to the initiator.
REQ-010 Port miso_oe, output, 1 bit: high while the responder is driving miso within a frame.
REQ-011 Port sample, output, DATA_W bits: current pattern value that the next frame transmits.
REQ-012 Port rx_word, output, FRAME_LEN bits: last complete word captured from mosi.
REQ-013 Port frame_done, output, 1 bit: one-clk pulse when a complete frame ends.
REQ-014 Port frame_abort, output, 1 bit: one-clk pulse when a frame ends short.

Function
REQ-015 cs_n, sclk and mosi SHALL each pass through a 2-flop synchronizer; edge detection SHALL use a third stage, for 3 clk of input-to-action latency.
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and WAIT_CS.
REQ-017 IDLE: on a synced falling edge of cs_n, the block SHALL load tx_sr = {LEAD_Z zeros, sample}, clear the bit counter, set miso_oe=1 and enter SHIFT.
REQ-018 In SHIFT, miso SHALL equal tx_sr MSB at all times, so the first bit (0) is valid from the cs_n fall.
REQ-019 In SHIFT, each synced sclk rising edge SHALL shift synced mosi into rx_sr LSB-first-in, so the first received bit ends up as the MSB.
REQ-020 In SHIFT, each synced sclk falling edge SHALL shift tx_sr left by one and increment the bit counter.
REQ-021 When the bit counter reaches FRAME_LEN, the FSM SHALL enter WAIT_CS, drive miso=0 and set miso_oe=0.
REQ-022 In WAIT_CS, sclk edges SHALL be ignored.
REQ-023 On a synced cs_n rise in WAIT_CS, the block SHALL: pulse frame_done for one clk, load rx_word <= rx_sr, update sample by +1 (direction=1) or -1 (direction=0) modulo 2^DATA_W, and return to IDLE.
REQ-024 Direction SHALL be sampled in the same clk as the cs_n rise.
REQ-025 A synced cs_n rise in SHIFT (bit counter < FRAME_LEN) SHALL pulse frame_abort for one clk and return to IDLE, leaving sample and rx_word unchanged, with miso=0 and miso_oe=0.
REQ-026 The sample counter SHALL wrap 4095 -> 0 going up and 0 -> 4095 going down (DATA_W=12), with no saturation.
REQ-027 sclk edges in IDLE SHALL be ignored.
REQ-028 If a cs_n edge and an sclk edge are detected in the same clk, the cs_n edge SHALL take priority.
REQ-029 frame_done and frame_abort SHALL be mutually exclusive and never asserted for consecutive clk within a single frame.
REQ-030 The sample output SHALL change only in the frame_done clk.

Reset
REQ-031 While reset is high at a clk rising edge, the block SHALL set: state=IDLE, miso=0, miso_oe=0, sample=0, rx_word=0, frame_done=0, frame_abort=0, all shift registers and the bit counter=0, and synchronizer stages to idle levels (cs_n=1, sclk=1, mosi=0).
REQ-032 Reset asserted mid-frame SHALL abandon the frame without a frame_done or frame_abort pulse.
REQ-033 After reset deasserts, a cs_n already held low SHALL NOT start a frame; only a new falling edge starts one.

Verification
REQ-034 Reset, direction=1, then one 16-bit frame with mosi=0xA5C3 -> miso bits 0000_0000_0000_0000, rx_word=0xA5C3, one frame_done pulse, sample=1.
REQ-035 Three complete frames with direction=1 -> miso carries 1, 2 and 3 in the low 12 bits; sample=4 after the third.
REQ-036 Preload via 4095 up-frames (or reset then a down-frame), direction=0 from sample=0 -> sample=0xFFF; the next frame transmits 0x0FFF.
REQ-037 cs_n raised after 9 sclk falls -> frame_abort pulse, no frame_done, sample and rx_word unchanged, miso_oe=0 within 4 clk.
REQ-038 Reset asserted after 5 bits -> all outputs at reset values; the next full frame transmits sample 0 correctly.
REQ-039 20 sclk pulses inside one frame -> only the first 16 are used, miso_oe drops after the 16th fall, and frame_done fires at the cs_n rise.
